// File: rtl/fp_acc_pkg.sv
// Shared definitions for the floating-point accumulate sequencer.
// Holds the FSM state encoding, exponent field bounds and a zero test.
package fp_acc_pkg;

    localparam logic [1:0] ST_CLR    = 2'd0;
    localparam logic [1:0] ST_ACCEPT = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_OUT    = 2'd3;

    localparam int FP_EXP_MSB = 30;
    localparam int FP_EXP_LSB = 23;

    localparam logic [31:0] FP_ZERO = 32'h0;

    // Zero and denormal words share an all-zero exponent. The core assumes
    // a hidden bit, so both are treated as +0.
    function automatic logic is_fp_zero(input logic [31:0] w);
        return (w[FP_EXP_MSB:FP_EXP_LSB] == '0);
    endfunction

endpackage

// File: rtl/fp_accum_seq.sv
// Initiator-side sequencer folding a stream of single-precision words into
// a running sum through an external adder core, one add at a time.
//
// Ports:
//   clock, reset               system clock, synchronous active-high reset
//   in_valid/in_ready/in_data  input word handshake, in_last ends a stream
//   out_valid/out_ready        result handshake
//   out_data, out_count        accumulated sum and words accepted
//   err                        sticky: a core operation timed out
//   core_rst/core_add          control pins of the adder core
//   core_a, core_b             operands (accumulator, latched input word)
//   core_done, core_sum        sticky completion flag and result of the core
module fp_accum_seq
    import fp_acc_pkg::*;
#(
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             err,
    output logic             core_rst,
    output logic             core_add,
    output logic [31:0]      core_a,
    output logic [31:0]      core_b,
    input  logic             core_done,
    input  logic [31:0]      core_sum
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [31:0]      acc;
    logic [31:0]      opb;
    logic             acc_empty;
    logic [CNT_W-1:0] count;
    logic             last_pending;
    logic [TMR_W-1:0] timer;
    logic             err_q;

    wire xfer = in_valid && (state == ST_ACCEPT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_CLR;
            acc          <= FP_ZERO;
            opb          <= FP_ZERO;
            acc_empty    <= 1'b1;
            count        <= '0;
            last_pending <= 1'b0;
            timer        <= '0;
            err_q        <= 1'b0;
        end else begin
            unique case (state)
                ST_CLR: begin
                    // One-cycle core re-arm; a finished stream goes to OUT.
                    state <= last_pending ? ST_OUT : ST_ACCEPT;
                end
                ST_ACCEPT: begin
                    if (xfer) begin
                        if (count != '1) count <= count + 1'b1;
                        last_pending <= in_last;
                        if (is_fp_zero(in_data)) begin
                            state <= in_last ? ST_OUT : ST_ACCEPT;
                        end else if (acc_empty) begin
                            // First non-zero word is loaded, not added.
                            acc       <= in_data;
                            acc_empty <= 1'b0;
                            state     <= in_last ? ST_OUT : ST_ACCEPT;
                        end else begin
                            opb   <= in_data;
                            timer <= '0;
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (core_done) begin
                        acc   <= core_sum;
                        state <= ST_CLR;
                    end else if (timer == TMR_LAST) begin
                        // Give up on this add; acc keeps its old value.
                        err_q <= 1'b1;
                        state <= ST_CLR;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        acc          <= FP_ZERO;
                        acc_empty    <= 1'b1;
                        count        <= '0;
                        last_pending <= 1'b0;
                        state        <= ST_CLR;
                    end
                end
                default: state <= ST_CLR;
            endcase
        end
    end

    assign in_ready  = (state == ST_ACCEPT);
    assign out_valid = (state == ST_OUT);
    assign out_data  = acc_empty ? FP_ZERO : acc;
    assign out_count = count;
    assign err       = err_q;

    // Reset reaches the core in the same cycle it is asserted.
    assign core_rst  = reset || (state == ST_CLR);
    assign core_add  = (state == ST_RUN);
    assign core_a    = acc;
    assign core_b    = opb;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Self-checking bench for fp_accum_seq with a latency-11 adder core model.
// Directed stream table plus timeout and mid-RUN reset sequences.
module tb_fp_accum_seq;

    localparam int L     = 11;
    localparam int CNT_W = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic             err;
    logic             core_rst;
    logic             core_add;
    logic [31:0]      core_a;
    logic [31:0]      core_b;
    logic             core_done;
    logic [31:0]      core_sum;

    int nchk = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    fp_accum_seq #(.TIMEOUT(32), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_count(out_count),
        .err(err),
        .core_rst(core_rst), .core_add(core_add),
        .core_a(core_a), .core_b(core_b),
        .core_done(core_done), .core_sum(core_sum)
    );

    // Core model: sum of the operand pairs used by this bench.
    function automatic logic [31:0] fadd(input logic [31:0] a,
                                         input logic [31:0] b);
        logic [63:0] k;
        k = {a, b};
        case (k)
            64'h3F800000_40000000: return 32'h40400000;
            64'h40400000_3F000000: return 32'h40600000;
            default:               return 32'hDEADBEEF;
        endcase
    endfunction

    bit          dead = 1'b0;
    logic        done_q = 1'b0;
    logic [31:0] sum_q = '0;
    int          ccnt = 0;

    always @(posedge clock) begin
        if (core_rst) begin
            done_q <= 1'b0;
            ccnt   <= 0;
        end else if (core_add && !done_q) begin
            if (ccnt == L - 1) begin
                done_q <= 1'b1;
                sum_q  <= fadd(core_a, core_b);
            end else begin
                ccnt <= ccnt + 1;
            end
        end
    end

    assign core_done = done_q && !dead;
    assign core_sum  = sum_q;

    // Activity monitor on the core pins.
    int   add_cyc = 0;
    int   add_eps = 0;
    int   rst_run = 0;
    int   last_gap = 0;
    logic add_q = 1'b0;

    always @(posedge clock) begin
        if (core_add && !add_q) begin
            add_eps  <= add_eps + 1;
            last_gap <= rst_run;
        end
        if (core_add) rst_run <= 0;
        else if (core_rst) rst_run <= rst_run + 1;
        if (core_add) add_cyc <= add_cyc + 1;
        add_q <= core_add;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one word and hold it until it transfers.
    task automatic send_word(input logic [31:0] w, input logic last);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        in_last  = last;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            nchk++;
            nerr++;
            $display("FAIL send_timeout: got no in_ready expected in_ready=1");
        end
    endtask

    // Wait for a result, check it, optionally stall, then accept it.
    task automatic get_out(input string tag, input logic [31:0] exp_d,
                           input int exp_c, input bit hold);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            nchk++;
            nerr++;
            $display("FAIL %s_out_timeout: got no out_valid expected 1", tag);
            return;
        end
        chk({tag, "_data"}, out_data, exp_d);
        chk({tag, "_count"}, 32'(out_count), 32'(exp_c));
        chk({tag, "_no_ready"}, 32'(in_ready), 32'd0);
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                tick();
                chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                chk({tag, "_hold_data"}, out_data, exp_d);
                chk({tag, "_hold_count"}, 32'(out_count), 32'(exp_c));
                chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    typedef struct {
        string       name;
        int          n;
        logic [31:0] w [4];
        logic [31:0] exp_d;
        int          exp_c;
        int          exp_eps;
        bit          imm;
        bit          hold;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int eps0;
        int cyc0;

        vecs[0] = '{"sum3", 3,
                    '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'h0},
                    32'h40600000, 3, 2, 1'b0, 1'b0};
        vecs[1] = '{"zero_first", 2,
                    '{32'h00000000, 32'h3F800000, 32'h0, 32'h0},
                    32'h3F800000, 2, 0, 1'b0, 1'b0};
        vecs[2] = '{"single_zero", 1,
                    '{32'h00000000, 32'h0, 32'h0, 32'h0},
                    32'h00000000, 1, 0, 1'b1, 1'b0};
        vecs[3] = '{"denorm", 2,
                    '{32'h00400000, 32'h40000000, 32'h0, 32'h0},
                    32'h40000000, 2, 0, 1'b0, 1'b0};
        vecs[4] = '{"hold", 2,
                    '{32'h3F800000, 32'h40000000, 32'h0, 32'h0},
                    32'h40400000, 2, 1, 1'b0, 1'b1};
        vecs[5] = '{"after_hold", 1,
                    '{32'h40000000, 32'h0, 32'h0, 32'h0},
                    32'h40000000, 1, 0, 1'b1, 1'b0};

        reset = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_core_add", 32'(core_add), 32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) begin
            eps0 = add_eps;
            for (int i = 0; i < vecs[v].n; i++)
                send_word(vecs[v].w[i], i == vecs[v].n - 1);
            if (vecs[v].imm)
                chk({vecs[v].name, "_imm_valid"}, 32'(out_valid), 32'd1);
            get_out(vecs[v].name, vecs[v].exp_d, vecs[v].exp_c,
                    vecs[v].hold);
            chk({vecs[v].name, "_adds"}, 32'(add_eps - eps0),
                32'(vecs[v].exp_eps));
            chk({vecs[v].name, "_err"}, 32'(err), 32'd0);
            if (v == 0)
                chk("sum3_rst_gap", 32'(last_gap), 32'd1);
        end

        // Core never completes: the add must abort after 32 cycles.
        dead = 1'b1;
        cyc0 = add_cyc;
        send_word(32'h3F800000, 1'b0);
        send_word(32'h40000000, 1'b1);
        get_out("timeout", 32'h3F800000, 2, 1'b0);
        chk("timeout_add_cycles", 32'(add_cyc - cyc0), 32'd32);
        chk("timeout_err", 32'(err), 32'd1);
        dead = 1'b0;

        // Reset three cycles into RUN.
        send_word(32'h3F800000, 1'b0);
        send_word(32'h40000000, 1'b1);
        chk("mid_run_add", 32'(core_add), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("mid_run_core_rst", 32'(core_rst), 32'd1);
        tick();
        reset = 1'b0;
        chk("post_rst_in_ready", 32'(in_ready), 32'd0);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_core_add", 32'(core_add), 32'd0);
        chk("post_rst_core_rst", 32'(core_rst), 32'd1);
        chk("post_rst_err", 32'(err), 32'd0);
        chk("post_rst_count", 32'(out_count), 32'd0);
        send_word(32'h40000000, 1'b1);
        chk("post_rst_imm", 32'(out_valid), 32'd1);
        get_out("post_rst", 32'h40000000, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
